// File: rtl/menu_pkg.sv
// Shared definitions for the photobooth menu controller.
//   stage_t      : menu stage encoding, matches the 2-bit stage output
//   DEF_*        : default option counts, layout and timeout
//   BTN_*        : bit positions of the buttons in the packed button vector
package menu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILTER = 2'd1,
    ST_THRESH = 2'd2,
    ST_DONE   = 2'd3
  } stage_t;

  localparam int DEF_NUM_FILTERS    = 6;
  localparam int DEF_FILTER_COLS    = 3;
  localparam int DEF_NUM_THRESH     = 4;
  localparam int DEF_FX0            = 120;
  localparam int DEF_FX_STEP        = 340;
  localparam int DEF_FY0            = 334;
  localparam int DEF_TX0            = 78;
  localparam int DEF_TX_STEP        = 256;
  localparam int DEF_TY0            = 560;
  localparam int DEF_TIMEOUT_CYCLES = 0;

  localparam int BTN_L = 2;
  localparam int BTN_M = 1;
  localparam int BTN_R = 0;

endpackage

// File: rtl/wrap_index_ctr.sv
// Wrapping up/down index counter with incremental row/column tracking.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   inc_i        : step forward, N-1 wraps to 0
//   dec_i        : step backward, 0 wraps to N-1 (inc_i wins if both set)
//   idx_o        : linear index
//   row_o, col_o : grid position for COLS options per row (COLS=0: one row)
module wrap_index_ctr #(
  parameter  int N    = 4,
  parameter  int COLS = 0,
  localparam int IW   = (N > 1) ? $clog2(N) : 1,
  localparam int C    = (COLS > 0) ? COLS : N,
  localparam int CW   = (C > 1) ? $clog2(C) : 1,
  localparam int ROWS = (N + C - 1) / C,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [IW-1:0] idx_o,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o
);

  // Grid position of the last option, resolved at elaboration time.
  localparam int LAST_ROW = (N - 1) / C;
  localparam int LAST_COL = (N - 1) % C;

  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  always_comb begin
    idx_d = idx_q;
    row_d = row_q;
    col_d = col_q;
    if (inc_i) begin
      if (idx_q == IW'(N - 1)) begin
        idx_d = '0;
        row_d = '0;
        col_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
        if (col_q == CW'(C - 1)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end else if (dec_i) begin
      if (idx_q == '0) begin
        idx_d = IW'(N - 1);
        row_d = RW'(LAST_ROW);
        col_d = CW'(LAST_COL);
      end else begin
        idx_d = idx_q - IW'(1);
        if (col_q == '0) begin
          col_d = CW'(C - 1);
          row_d = row_q - RW'(1);
        end else begin
          col_d = col_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      idx_q <= idx_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign idx_o = idx_q;
  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/menu_select_ctrl.sv
// Photobooth menu controller: IDLE -> FILTER -> THRESH -> DONE selection flow
// driven by left/middle/right button levels, with arrow cursor placement.
//   clk_in, rst_in         : pixel clock, asynchronous active-high reset
//   sw_state               : allows leaving IDLE
//   left_in/middle_in/right_in : debounced button levels
//   stage_out              : 0 IDLE, 1 FILTER, 2 THRESH, 3 DONE
//   filter_select_out      : current filter index
//   threshold_select_out   : current threshold index
//   cursor_x_out/_y_out    : arrow sprite position
//   cursor_up_out          : 1 up-arrow, 0 down-arrow
//   config_valid_out       : high while in DONE
//   config_strobe_out      : one-cycle pulse on each entry to DONE
module menu_select_ctrl
  import menu_pkg::*;
#(
  parameter int NUM_FILTERS    = DEF_NUM_FILTERS,
  parameter int FILTER_COLS    = DEF_FILTER_COLS,
  parameter int NUM_THRESH     = DEF_NUM_THRESH,
  parameter int FX0            = DEF_FX0,
  parameter int FX_STEP        = DEF_FX_STEP,
  parameter int FY0            = DEF_FY0,
  parameter int TX0            = DEF_TX0,
  parameter int TX_STEP        = DEF_TX_STEP,
  parameter int TY0            = DEF_TY0,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          sw_state,
  input  logic                          left_in,
  input  logic                          middle_in,
  input  logic                          right_in,
  output logic [1:0]                    stage_out,
  output logic [$clog2(NUM_FILTERS)-1:0] filter_select_out,
  output logic [$clog2(NUM_THRESH)-1:0]  threshold_select_out,
  output logic [10:0]                   cursor_x_out,
  output logic [9:0]                    cursor_y_out,
  output logic                          cursor_up_out,
  output logic                          config_valid_out,
  output logic                          config_strobe_out
);

  localparam int FW    = $clog2(NUM_FILTERS);
  localparam int TW    = $clog2(NUM_THRESH);
  localparam int FCW   = (FILTER_COLS > 1) ? $clog2(FILTER_COLS) : 1;
  localparam int FROWS = (NUM_FILTERS + FILTER_COLS - 1) / FILTER_COLS;
  localparam int FRW   = (FROWS > 1) ? $clog2(FROWS) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  // Button edge detection, packed as {left, middle, right}.
  logic [2:0] prev_q, click_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      prev_q  <= '0;
      click_q <= '0;
    end else begin
      prev_q  <= {left_in, middle_in, right_in};
      click_q <= {left_in, middle_in, right_in} & ~prev_q;
    end
  end

  // Middle beats BACK (left+right together), BACK beats single moves.
  logic mid_c, back_c, mv_r, mv_l, any_c;
  assign mid_c  = click_q[BTN_M];
  assign back_c = click_q[BTN_L] & click_q[BTN_R];
  assign mv_r   = ~mid_c & click_q[BTN_R] & ~click_q[BTN_L];
  assign mv_l   = ~mid_c & click_q[BTN_L] & ~click_q[BTN_R];
  assign any_c  = |click_q;

  stage_t          stage_q, stage_d;
  logic            valid_q, strobe_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            active, timeout_hit;

  assign active      = (stage_q == ST_FILTER) || (stage_q == ST_THRESH);
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && active && !any_c &&
                       (to_cnt_q == TO_W'(TO_LAST));

  always_comb begin
    stage_d = stage_q;
    case (stage_q)
      ST_IDLE:   if (mid_c && sw_state) stage_d = ST_FILTER;
      ST_FILTER: begin
        if (mid_c)            stage_d = ST_THRESH;
        else if (back_c)      stage_d = ST_IDLE;
        else if (timeout_hit) stage_d = ST_DONE;
      end
      ST_THRESH: begin
        if (mid_c)            stage_d = ST_DONE;
        else if (back_c)      stage_d = ST_FILTER;
        else if (timeout_hit) stage_d = ST_DONE;
      end
      ST_DONE: begin
        if (mid_c)            stage_d = ST_FILTER;
        else if (back_c)      stage_d = ST_THRESH;
      end
      default:                stage_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stage_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      stage_q  <= stage_d;
      valid_q  <= (stage_d == ST_DONE);
      strobe_q <= (stage_d == ST_DONE) && (stage_q != ST_DONE);
      if (TIMEOUT_CYCLES == 0 || !active || any_c || stage_d != stage_q)
        to_cnt_q <= '0;
      else
        to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // Index counters only move while their own stage is active.
  logic [FW-1:0]  f_idx;
  logic [FRW-1:0] f_row;
  logic [FCW-1:0] f_col;
  logic [TW-1:0]  t_idx;
  logic           t_row;
  logic [TW-1:0]  t_col;

  wrap_index_ctr #(.N(NUM_FILTERS), .COLS(FILTER_COLS)) u_filter_ctr (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .inc_i ((stage_q == ST_FILTER) && mv_r),
    .dec_i ((stage_q == ST_FILTER) && mv_l),
    .idx_o (f_idx),
    .row_o (f_row),
    .col_o (f_col)
  );

  wrap_index_ctr #(.N(NUM_THRESH), .COLS(0)) u_thresh_ctr (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .inc_i ((stage_q == ST_THRESH) && mv_r),
    .dec_i ((stage_q == ST_THRESH) && mv_l),
    .idx_o (t_idx),
    .row_o (t_row),
    .col_o (t_col)
  );

  // Threshold menu is a single row; its row/col views are redundant.
  logic unused_t_grid;
  assign unused_t_grid = ^{t_row, t_col};

  // Cursor follows the registered indices, so it lags them by one cycle.
  logic [10:0] cur_x_q;
  logic [9:0]  cur_y_q;
  logic        cur_up_q;
  logic [10:0] f_x, t_x;

  assign f_x = 11'(FX0) + 11'(f_col) * 11'(FX_STEP);
  assign t_x = 11'(TX0) + 11'(t_idx) * 11'(TX_STEP);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cur_x_q  <= 11'(FX0);
      cur_y_q  <= 10'(FY0);
      cur_up_q <= 1'b1;
    end else begin
      case (stage_q)
        ST_FILTER: begin
          cur_x_q  <= f_x;
          cur_y_q  <= 10'(FY0);
          cur_up_q <= (f_row == '0);
        end
        ST_THRESH: begin
          cur_x_q  <= t_x;
          cur_y_q  <= 10'(TY0);
          cur_up_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stage_out            = stage_q;
  assign filter_select_out    = f_idx;
  assign threshold_select_out = t_idx;
  assign cursor_x_out         = cur_x_q;
  assign cursor_y_out         = cur_y_q;
  assign cursor_up_out        = cur_up_q;
  assign config_valid_out     = valid_q;
  assign config_strobe_out    = strobe_q;

endmodule

// File: tb/tb_menu_select_ctrl.sv
module tb_menu_select_ctrl;

  localparam int NF = 6;
  localparam int FC = 3;
  localparam int NT = 4;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst, sw, bl, bm, br;
  logic [1:0]  stage;
  logic [2:0]  fsel;
  logic [1:0]  tsel;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic        cup, cvalid, cstrobe;

  always #5 clk = ~clk;

  menu_select_ctrl #(
    .NUM_FILTERS(NF), .FILTER_COLS(FC), .NUM_THRESH(NT),
    .FX0(120), .FX_STEP(340), .FY0(334),
    .TX0(78), .TX_STEP(256), .TY0(560),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk), .rst_in(rst), .sw_state(sw),
    .left_in(bl), .middle_in(bm), .right_in(br),
    .stage_out(stage), .filter_select_out(fsel), .threshold_select_out(tsel),
    .cursor_x_out(cx), .cursor_y_out(cy), .cursor_up_out(cup),
    .config_valid_out(cvalid), .config_strobe_out(cstrobe)
  );

  int total = 0;
  int bad   = 0;
  int n_strobe = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: menu rules applied per clock edge.
  int m_stage, m_f, m_t, m_quiet, m_x, m_y;
  bit m_up, m_valid, m_strobe;
  bit pl, pm, pr, cl, cm, cr;
  int ns, nf, nt;
  bit anyc, back, act, fire;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stage = 0; m_f = 0; m_t = 0; m_quiet = 0;
      m_x = 120; m_y = 334; m_up = 1; m_valid = 0; m_strobe = 0;
      pl = 0; pm = 0; pr = 0; cl = 0; cm = 0; cr = 0;
    end else begin
      if (m_stage == 1) begin
        m_x = 120 + (m_f % FC) * 340; m_y = 334; m_up = (m_f / FC) == 0;
      end else if (m_stage == 2) begin
        m_x = 78 + m_t * 256; m_y = 560; m_up = 1;
      end
      ns = m_stage; nf = m_f; nt = m_t;
      anyc = cl | cm | cr;
      back = cl & cr;
      act  = (m_stage == 1) || (m_stage == 2);
      fire = act && !anyc && (m_quiet + 1 == TO);
      case (m_stage)
        0: if (cm && sw) ns = 1;
        1: if (cm) ns = 2; else if (back) ns = 0;
           else if (cr) nf = (m_f + 1) % NF; else if (cl) nf = (m_f + NF - 1) % NF;
           else if (fire) ns = 3;
        2: if (cm) ns = 3; else if (back) ns = 1;
           else if (cr) nt = (m_t + 1) % NT; else if (cl) nt = (m_t + NT - 1) % NT;
           else if (fire) ns = 3;
        default: if (cm) ns = 1; else if (back) ns = 2;
      endcase
      if (!act || anyc || ns != m_stage) m_quiet = 0; else m_quiet++;
      m_strobe = (ns == 3) && (m_stage != 3);
      m_valid  = (ns == 3);
      m_stage = ns; m_f = nf; m_t = nt;
      cl = bl && !pl; cm = bm && !pm; cr = br && !pr;
      pl = bl; pm = bm; pr = br;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("stage", stage, m_stage);
      chk("filter", fsel, m_f);
      chk("thresh", tsel, m_t);
      chk("cursor_x", cx, m_x);
      chk("cursor_y", cy, m_y);
      chk("cursor_up", cup, m_up);
      chk("valid", cvalid, m_valid);
      chk("strobe", cstrobe, m_strobe);
      if (cstrobe) n_strobe++;
    end
  end

  task automatic press(input bit l, input bit m, input bit r);
    @(negedge clk); bl = l; bm = m; br = r;
    @(negedge clk); bl = 0; bm = 0; br = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (stage != 2'd3 && n < 200) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_filter"}, fsel, 0);
    chk({tag, "_thresh"}, tsel, 0);
    chk({tag, "_x"}, cx, 120);
    chk({tag, "_y"}, cy, 334);
    chk({tag, "_up"}, cup, 1);
    chk({tag, "_valid"}, cvalid, 0);
    chk({tag, "_strobe"}, cstrobe, 0);
  endtask

  int s0, n, hold;

  initial begin
    rst = 1; sw = 0; bl = 0; bm = 0; br = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_reset_vals("rst");

    press(0, 1, 0);
    chk("sw0_stay_idle", stage, 0);
    sw = 1;
    press(0, 1, 0);
    chk("enter_filter", stage, 1);
    chk("f0_x", cx, 120); chk("f0_y", cy, 334); chk("f0_up", cup, 1);

    repeat (3) press(0, 0, 1);
    chk("f3_idx", fsel, 3); chk("f3_x", cx, 120); chk("f3_up", cup, 0);
    repeat (3) press(0, 0, 1);
    chk("f_wrap_up", fsel, 0);
    press(1, 0, 0);
    chk("f_wrap_down", fsel, 5); chk("f5_x", cx, 800);
    chk("f5_y", cy, 334); chk("f5_up", cup, 0);

    press(0, 1, 0);
    chk("enter_thresh", stage, 2);
    press(1, 0, 0);
    chk("t_wrap_down", tsel, 3); chk("t3_x", cx, 846); chk("t3_y", cy, 560);
    s0 = n_strobe;
    press(0, 1, 0);
    chk("enter_done", stage, 3); chk("done_valid", cvalid, 1);
    chk("done_one_strobe", n_strobe - s0, 1); chk("strobe_dropped", cstrobe, 0);

    press(1, 0, 1);
    chk("back_to_thresh", stage, 2);
    press(1, 0, 1);
    chk("back_to_filter", stage, 1);
    chk("back_f_kept", fsel, 5); chk("back_t_kept", tsel, 3);

    // Inactivity timeout in THRESH.
    press(0, 1, 0);
    s0 = n_strobe;
    wait_done(n);
    chk("timeout_cycles", n, 49);
    @(negedge clk);
    chk("timeout_one_strobe", n_strobe - s0, 1);
    chk("timeout_t_kept", tsel, 3);

    // A click one edge before expiry restarts the count.
    press(0, 1, 0);
    press(0, 1, 0);
    repeat (45) @(negedge clk);
    press(1, 0, 0);
    chk("restart_still_thresh", stage, 2);
    chk("restart_moved", tsel, 2);
    wait_done(n);
    chk("restart_cycles", n, 49);

    // Asynchronous reset while in DONE, off the clock edge.
    @(posedge clk); #2 rst = 1;
    #1 chk_reset_vals("async");
    repeat (2) @(negedge clk);
    rst = 0;
    s0 = n_strobe;
    repeat (3) @(negedge clk);
    chk("no_strobe_after_rst", n_strobe - s0, 0);

    // Randomized button traffic.
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      {bl, bm, br} = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) sw = ~sw;
      hold = ($urandom_range(0, 24) == 0) ? $urandom_range(45, 60) : $urandom_range(0, 4);
      repeat (hold) @(negedge clk);
    end
    @(negedge clk); bl = 0; bm = 0; br = 0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
